// File: rtl/cselector_n_sync.sv
// -----------------------------------------------------------------------------
// cselector_n_sync
//
// Clocked conditional fork with join for the cache control path. A drive token
// is accepted together with the channel valid vector that is present in the
// same cycle. After DELAY cycles the selected channels get one drive pulse. The
// block then waits until every selected channel has returned a free pulse
// before it takes the next token. A one-deep pending slot holds a drive that
// arrives while a token is in flight. A drive that arrives when the slot is
// already full is dropped, and the sticky overflow flag is set.
//
// Handshake: there is no valid/ready pair. Every transfer is a single-cycle
// pulse. i_drive is sampled once, and i_valid is captured in that same cycle,
// so upstream may change i_valid afterwards. o_driveNext and o_done are
// one-cycle pulses. i_freeNext bits are single-cycle pulses that are counted
// only while a token is being driven or awaited.
//
// Parameters
//   N      number of downstream channels (2..32)
//   DELAY  cycles from o_fire to o_driveNext (0..255)
//   MODE   0 = multicast to all valid channels,
//          1 = only the lowest-index valid channel
//
// Ports
//   clk          clock
//   rstn         asynchronous active-low reset
//   i_drive      drive pulse from upstream
//   i_valid      channel select vector, sampled with i_drive
//   o_free       pulse: a token was consumed (launched)
//   o_fire       pulse, coincident with o_free
//   o_driveNext  per-channel drive pulse for the selected channels
//   i_freeNext   per-channel completion pulses from downstream
//   o_done       pulse: all selected channels have returned free
//   o_busy       high whenever the FSM is not idle
//   o_overflow   sticky: a drive was dropped (cleared only by reset)
//   dbg_state    current FSM state (0 idle, 1 delay, 2 drive, 3 wait)
// -----------------------------------------------------------------------------
module cselector_n_sync #(
   parameter int N     = 8,
   parameter int DELAY = 8,
   parameter int MODE  = 0
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_drive,
   input  logic [N-1:0] i_valid,
   output logic         o_free,
   output logic         o_fire,
   output logic [N-1:0] o_driveNext,
   input  logic [N-1:0] i_freeNext,
   output logic         o_done,
   output logic         o_busy,
   output logic         o_overflow,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DLY   = 2'd1,
      ST_DRIVE = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   localparam int CW = (DELAY < 1) ? 1 : $clog2(DELAY + 1);
   localparam logic [CW-1:0] DELAY_C = CW'(DELAY);

   // registered state
   state_t         state;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   sel;
   logic [N-1:0]   got;
   logic           pend_v;
   logic [N-1:0]   pend_val;

   // next-state values
   state_t         state_nxt;
   logic [CW-1:0]  cnt_nxt;
   logic [N-1:0]   sel_nxt;
   logic [N-1:0]   got_nxt;
   logic           pend_v_nxt;
   logic [N-1:0]   pend_val_nxt;

   // decision strobes from the next-state logic
   logic           launch;
   logic           complete;
   logic           drop;
   logic [N-1:0]   launch_vec;
   logic [N-1:0]   launch_sel;
   logic [N-1:0]   got_acc;

   // output register inputs
   logic           fire_d;
   logic           done_d;
   logic [N-1:0]   drive_d;
   logic           busy_d;
   logic           ovf_d;

   // output registers
   logic           fire_q;
   logic           free_q;
   logic           done_q;
   logic [N-1:0]   drive_q;
   logic           busy_q;
   logic           ovf_q;

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         sel      <= '0;
         got      <= '0;
         pend_v   <= 1'b0;
         pend_val <= '0;
         fire_q   <= 1'b0;
         free_q   <= 1'b0;
         done_q   <= 1'b0;
         drive_q  <= '0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         sel      <= sel_nxt;
         got      <= got_nxt;
         pend_v   <= pend_v_nxt;
         pend_val <= pend_val_nxt;
         fire_q   <= fire_d;
         free_q   <= fire_d;
         done_q   <= done_d;
         drive_q  <= drive_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // The pending slot has priority over a fresh drive.
      launch_vec = pend_v ? pend_val : i_valid;
      // In MODE 1, v & -v isolates the lowest set bit.
      launch_sel = (MODE != 0) ? (launch_vec & (~launch_vec + N'(1))) : launch_vec;
      // Free pulses that arrive in the current cycle count toward the join.
      got_acc    = got | (i_freeNext & sel);

      state_nxt    = state;
      cnt_nxt      = cnt;
      sel_nxt      = sel;
      got_nxt      = got;
      pend_v_nxt   = pend_v;
      pend_val_nxt = pend_val;
      launch       = 1'b0;
      complete     = 1'b0;
      drop         = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (pend_v || i_drive) begin
               launch  = 1'b1;
               sel_nxt = launch_sel;
               cnt_nxt = DELAY_C;
               got_nxt = '0;
               if (launch_sel == '0)
                  state_nxt = ST_IDLE;
               else if (DELAY == 0)
                  state_nxt = ST_DRIVE;
               else
                  state_nxt = ST_DLY;
               // The slot was consumed. A drive in this cycle refills it.
               if (pend_v) begin
                  pend_v_nxt   = i_drive;
                  pend_val_nxt = i_drive ? i_valid : '0;
               end
            end
         end
         ST_DLY: begin
            cnt_nxt = cnt - CW'(1);
            if (cnt <= CW'(1))
               state_nxt = ST_DRIVE;
         end
         ST_DRIVE, ST_WAIT: begin
            if (got_acc == sel) begin
               complete  = 1'b1;
               got_nxt   = '0;
               state_nxt = ST_IDLE;
            end else begin
               got_nxt   = got_acc;
               state_nxt = ST_WAIT;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // While a token is in flight, which includes the cycle in which its join
      // completes, a new drive can only go into the slot or be dropped.
      if ((state != ST_IDLE) && i_drive) begin
         if (!pend_v) begin
            pend_v_nxt   = 1'b1;
            pend_val_nxt = i_valid;
         end else begin
            drop = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output logic (feeds the output registers)
   // ---------------------------------------------------------------------------
   always_comb begin
      fire_d  = launch;
      // An empty selection completes in the same cycle that it fires.
      done_d  = complete | (launch && (launch_sel == '0));
      drive_d = (state_nxt == ST_DRIVE) ? sel_nxt : '0;
      busy_d  = (state_nxt != ST_IDLE);
      ovf_d   = ovf_q | drop;
   end

   assign o_fire      = fire_q;
   assign o_free      = free_q;
   assign o_done      = done_q;
   assign o_driveNext = drive_q;
   assign o_busy      = busy_q;
   assign o_overflow  = ovf_q;
   assign dbg_state   = state;

endmodule

// File: tb/tb_cselector_n_sync.sv
// -----------------------------------------------------------------------------
// tb_cselector_n_sync
//
// Three instances share one stimulus stream:
//   u0: N=8 DELAY=8 MODE=0
//   u1: N=8 DELAY=3 MODE=1
//   u2: N=8 DELAY=0 MODE=0
// A transaction-level model predicts the outputs of each instance for the next
// cycle. It tracks the token in flight, the absolute cycle at which its drive
// must appear, the returned frees, the pending slot and the overflow flag.
// A compare process at every falling edge checks all outputs against the
// predictions queued one cycle earlier. Directed scenarios add literal checks
// at hand-computed cycles. A randomized phase follows the directed scenarios.
// -----------------------------------------------------------------------------
module tb_cselector_n_sync;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------------
   // DUT signals
   // ---------------------------------------------------------------------------
   logic            i_drive    = 1'b0;
   logic [7:0]      i_valid    = 8'h00;
   logic [7:0]      i_freeNext = 8'h00;
   logic [2:0]      free_o, fire_o, done_o, busy_o, ovf_o;
   logic [2:0][7:0] drv_o;
   logic [2:0][1:0] dbg_o;

   cselector_n_sync #(.N(8), .DELAY(8), .MODE(0)) u0 (
      .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_valid(i_valid),
      .o_free(free_o[0]), .o_fire(fire_o[0]), .o_driveNext(drv_o[0]),
      .i_freeNext(i_freeNext), .o_done(done_o[0]), .o_busy(busy_o[0]),
      .o_overflow(ovf_o[0]), .dbg_state(dbg_o[0]));

   cselector_n_sync #(.N(8), .DELAY(3), .MODE(1)) u1 (
      .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_valid(i_valid),
      .o_free(free_o[1]), .o_fire(fire_o[1]), .o_driveNext(drv_o[1]),
      .i_freeNext(i_freeNext), .o_done(done_o[1]), .o_busy(busy_o[1]),
      .o_overflow(ovf_o[1]), .dbg_state(dbg_o[1]));

   cselector_n_sync #(.N(8), .DELAY(0), .MODE(0)) u2 (
      .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_valid(i_valid),
      .o_free(free_o[2]), .o_fire(fire_o[2]), .o_driveNext(drv_o[2]),
      .i_freeNext(i_freeNext), .o_done(done_o[2]), .o_busy(busy_o[2]),
      .o_overflow(ovf_o[2]), .dbg_state(dbg_o[2]));

   // ---------------------------------------------------------------------------
   // Scoreboard bookkeeping
   // ---------------------------------------------------------------------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // {driveNext[7:0], fire, free, done, busy, overflow}
   function automatic logic [12:0] dut_word(input int k);
      return {drv_o[k], fire_o[k], free_o[k], done_o[k], busy_o[k], ovf_o[k]};
   endfunction

   // ---------------------------------------------------------------------------
   // Behavioural model (one per instance)
   // ---------------------------------------------------------------------------
   int         dly_p[3]  = '{8, 3, 0};
   int         mode_p[3] = '{0, 1, 0};
   bit         m_active[3];
   int         m_drive_at[3];
   logic [7:0] m_sel[3];
   logic [7:0] m_got[3];
   bit         m_pend_v[3];
   logic [7:0] m_pend_val[3];
   bit         m_ovf[3];

   function automatic logic [7:0] lowest_bit(input logic [7:0] v);
      for (int i = 0; i < 8; i++)
         if (v[i]) return 8'(1 << i);
      return 8'h00;
   endfunction

   task automatic model_reset(input int k);
      m_active[k]   = 1'b0;
      m_drive_at[k] = 0;
      m_sel[k]      = 8'h00;
      m_got[k]      = 8'h00;
      m_pend_v[k]   = 1'b0;
      m_pend_val[k] = 8'h00;
      m_ovf[k]      = 1'b0;
   endtask

   // Consume the inputs of the current cycle and return the outputs
   // expected in the next cycle.
   task automatic model_step(input int k, output logic [12:0] w);
      logic       fire, done;
      logic [7:0] tok, drv;
      fire = 1'b0;
      done = 1'b0;
      if (!m_active[k]) begin
         if (m_pend_v[k] || i_drive) begin
            tok = m_pend_v[k] ? m_pend_val[k] : i_valid;
            if (m_pend_v[k]) begin
               m_pend_v[k]   = i_drive;
               m_pend_val[k] = i_valid;
            end
            m_sel[k] = (mode_p[k] != 0) ? lowest_bit(tok) : tok;
            fire = 1'b1;
            if (m_sel[k] == 8'h00) begin
               done = 1'b1;
            end else begin
               m_active[k]   = 1'b1;
               m_drive_at[k] = cyc + 1 + dly_p[k];
               m_got[k]      = 8'h00;
            end
         end
      end else begin
         if (i_drive) begin
            if (!m_pend_v[k]) begin
               m_pend_v[k]   = 1'b1;
               m_pend_val[k] = i_valid;
            end else begin
               m_ovf[k] = 1'b1;
            end
         end
         if (cyc >= m_drive_at[k]) begin
            m_got[k] = m_got[k] | (i_freeNext & m_sel[k]);
            if (m_got[k] == m_sel[k]) begin
               done        = 1'b1;
               m_active[k] = 1'b0;
            end
         end
      end
      drv = (m_active[k] && (m_drive_at[k] == cyc + 1)) ? m_sel[k] : 8'h00;
      w = {drv, fire, fire, done, m_active[k], m_ovf[k]};
   endtask

   // ---------------------------------------------------------------------------
   // Compare process: expected queue, checked at every falling edge
   // ---------------------------------------------------------------------------
   logic [38:0] exp_q[$];

   always @(negedge clk) begin
      logic [38:0] cur;
      logic [38:0] nxt;
      logic [12:0] w;
      if (!rstn) begin
         exp_q.delete();
         cur = '0;
         for (int k = 0; k < 3; k++) model_reset(k);
      end else if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
      end else begin
         cur = '0;
      end
      for (int k = 0; k < 3; k++)
         chk($sformatf("cycle_u%0d", k), 32'(dut_word(k)), 32'(cur[13*k +: 13]));
      if (rstn) begin
         nxt = '0;
         for (int k = 0; k < 3; k++) begin
            model_step(k, w);
            nxt[13*k +: 13] = w;
         end
         exp_q.push_back(nxt);
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_to(input int c);
      while (cyc < c) step();
   endtask

   // Return frees on every channel until all instances go idle. Each instance
   // can hold at most one token in flight and one in the slot.
   task automatic flush();
      i_drive = 1'b0;
      for (int j = 0; j < 40; j++) begin
         step();
         i_freeNext = 8'hFF;
      end
      step();
      i_freeNext = 8'h00;
      step();
      @(negedge clk);
      chk("flush_idle", 32'(busy_o), 32'h0);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int t;
      logic [2:0] acts;

      // reset state
      repeat (3) step();
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk($sformatf("reset_u%0d", k), 32'(dut_word(k)), 32'h0);
      chk("reset_dbg", 32'(dbg_o), 32'h0);
      step();
      rstn = 1'b1;
      step();

      // Multicast, u0: valid 0x25, frees bit0 @t+12, bit5 @t+15, bit2 @t+20.
      t = cyc + 1;
      go_to(t);      i_drive = 1'b1; i_valid = 8'h25;
      go_to(t + 1);  i_drive = 1'b0; i_valid = 8'($urandom);
      @(negedge clk);
      chk("s1_fire", 32'(fire_o[0]), 32'h1);
      chk("s1_free", 32'(free_o[0]), 32'h1);
      go_to(t + 8);  @(negedge clk); chk("s1_drv_early", 32'(drv_o[0]), 32'h0);
      go_to(t + 9);  @(negedge clk); chk("s1_drv", 32'(drv_o[0]), 32'h25);
      go_to(t + 10); @(negedge clk); chk("s1_drv_late", 32'(drv_o[0]), 32'h0);
      go_to(t + 12); i_freeNext = 8'h01;
      go_to(t + 13); i_freeNext = 8'h00;
      go_to(t + 15); i_freeNext = 8'h20;
      go_to(t + 16); i_freeNext = 8'h00;
      go_to(t + 20); i_freeNext = 8'h04;
      @(negedge clk); chk("s1_done_early", 32'(done_o[0]), 32'h0);
      go_to(t + 21); i_freeNext = 8'h00;
      @(negedge clk);
      chk("s1_done", 32'(done_o[0]), 32'h1);
      chk("s1_idle", 32'(busy_o[0]), 32'h0);
      flush();

      // Priority mode, u1 (DELAY=3): valid 0x30 selects 0x10 only.
      t = cyc + 1;
      go_to(t);     i_drive = 1'b1; i_valid = 8'h30;
      go_to(t + 1); i_drive = 1'b0; i_valid = 8'($urandom);
      go_to(t + 4); @(negedge clk); chk("s2_drv", 32'(drv_o[1]), 32'h10);
      go_to(t + 6); i_freeNext = 8'h20;
      go_to(t + 7); i_freeNext = 8'h00;
      @(negedge clk);
      chk("s2_ignore_done", 32'(done_o[1]), 32'h0);
      chk("s2_ignore_busy", 32'(busy_o[1]), 32'h1);
      go_to(t + 8); i_freeNext = 8'h10;
      go_to(t + 9); i_freeNext = 8'h00;
      @(negedge clk); chk("s2_done", 32'(done_o[1]), 32'h1);
      flush();

      // Empty selection: fire, free and done together, never busy.
      t = cyc + 1;
      go_to(t);     i_drive = 1'b1; i_valid = 8'h00;
      go_to(t + 1); i_drive = 1'b0;
      @(negedge clk);
      chk("s3_fire", 32'(fire_o[0]), 32'h1);
      chk("s3_free", 32'(free_o[0]), 32'h1);
      chk("s3_done", 32'(done_o[0]), 32'h1);
      chk("s3_busy", 32'(busy_o[0]), 32'h0);
      chk("s3_done_u2", 32'(done_o[2]), 32'h1);
      go_to(t + 3); @(negedge clk);
      chk("s3_drv", 32'(drv_o[0]), 32'h0);
      chk("s3_busy_all", 32'(busy_o), 32'h0);

      // Pending slot and overflow, u0: A @t, B @t+11 (slot), C @t+13 (dropped).
      t = cyc + 1;
      go_to(t);      i_drive = 1'b1; i_valid = 8'h03;
      go_to(t + 1);  i_drive = 1'b0;
      go_to(t + 11); i_drive = 1'b1; i_valid = 8'h0C;
      go_to(t + 12); i_drive = 1'b0;
      go_to(t + 13); i_drive = 1'b1; i_valid = 8'h30;
      @(negedge clk); chk("s4_ovf_before", 32'(ovf_o[0]), 32'h0);
      go_to(t + 14); i_drive = 1'b0;
      @(negedge clk); chk("s4_ovf", 32'(ovf_o[0]), 32'h1);
      go_to(t + 15); i_freeNext = 8'h03;
      go_to(t + 16); i_freeNext = 8'h00;
      @(negedge clk);
      chk("s4_doneA", 32'(done_o[0]), 32'h1);
      chk("s4_no_fire_in_done", 32'(fire_o[0]), 32'h0);
      go_to(t + 17); @(negedge clk); chk("s4_fireB", 32'(fire_o[0]), 32'h1);
      go_to(t + 25); @(negedge clk); chk("s4_drvB", 32'(drv_o[0]), 32'h0C);
      go_to(t + 27); i_freeNext = 8'h0C;
      go_to(t + 28); i_freeNext = 8'h00;
      @(negedge clk); chk("s4_doneB", 32'(done_o[0]), 32'h1);
      acts = 3'b000;
      for (int c = t + 29; c <= t + 40; c++) begin
         go_to(c);
         @(negedge clk);
         acts[0] = acts[0] | fire_o[0];
      end
      chk("s4_C_dropped", 32'(acts), 32'h0);
      chk("s4_ovf_sticky", 32'(ovf_o[0]), 32'h1);
      flush();

      // DELAY=0, u2: free returned in the drive cycle, plus a queued token.
      t = cyc + 1;
      go_to(t);     i_drive = 1'b1; i_valid = 8'h81;
      go_to(t + 1); i_drive = 1'b1; i_valid = 8'h42; i_freeNext = 8'h81;
      @(negedge clk);
      chk("s5_drv", 32'(drv_o[2]), 32'h81);
      chk("s5_fire", 32'(fire_o[2]), 32'h1);
      go_to(t + 2); i_drive = 1'b0; i_freeNext = 8'h00;
      @(negedge clk);
      chk("s5_done", 32'(done_o[2]), 32'h1);
      chk("s5_busy", 32'(busy_o[2]), 32'h0);
      go_to(t + 3); @(negedge clk);
      chk("s5_fire2", 32'(fire_o[2]), 32'h1);
      chk("s5_drv2", 32'(drv_o[2]), 32'h42);
      flush();

      // Reset during WAIT with a token in the slot.
      t = cyc + 1;
      go_to(t);      i_drive = 1'b1; i_valid = 8'h0F;
      go_to(t + 1);  i_drive = 1'b0;
      go_to(t + 11); i_drive = 1'b1; i_valid = 8'h01;
      go_to(t + 12); i_drive = 1'b0; rstn = 1'b0;
      @(negedge clk);
      chk("s6_rst_u0", 32'(dut_word(0)), 32'h0);
      chk("s6_rst_ovf", 32'(ovf_o), 32'h0);
      chk("s6_rst_busy", 32'(busy_o), 32'h0);
      go_to(t + 14); rstn = 1'b1;
      acts = 3'b000;
      for (int c = t + 14; c <= t + 35; c++) begin
         go_to(c);
         @(negedge clk);
         acts = acts | fire_o | done_o | busy_o;
      end
      chk("s6_quiet", 32'(acts), 32'h0);

      // Randomized traffic, with one reset in the middle.
      for (int i = 0; i < 1500; i++) begin
         step();
         i_drive    = ($urandom_range(0, 5) == 0);
         i_valid    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         i_freeNext = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         if (i == 700) rstn = 1'b0;
         if (i == 703) rstn = 1'b1;
      end
      i_drive = 1'b0;
      flush();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Watchdog: the stimulus above is bounded, so this fires only on a hang.
   initial begin
      #1000000;
      $display("FAIL watchdog: still running at cycle %0d, required finish before 100000", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
